// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// mem_arbiter : round-robin req/ready arbiter (core vs loader, loader lock)
//               in front of a single-port memory with RD_LAT read latency.
// Revision    : 1.0
// ============================================================================
module mem_arbiter #(
    parameter int AW     = 32,
    parameter int DW     = 32,
    parameter int RD_LAT = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          c_req,
    input  logic          c_we,
    input  logic [AW-1:0] c_addr,
    input  logic [DW-1:0] c_wdata,
    output logic          c_ready,
    output logic [DW-1:0] c_rdata,
    input  logic          l_req,
    input  logic          l_we,
    input  logic [AW-1:0] l_addr,
    input  logic [DW-1:0] l_wdata,
    input  logic          l_lock,
    output logic          l_ready,
    output logic [DW-1:0] l_rdata,
    output logic          m_en,
    output logic          m_we,
    output logic [AW-1:0] m_addr,
    output logic [DW-1:0] m_wdata,
    input  logic [DW-1:0] m_rdata,
    output logic [1:0]    grant
);

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_WAIT, S_RESP} state_t;

    localparam logic [1:0] WAIT_LAST = 2'((RD_LAT > 1) ? (RD_LAT - 2) : 0);

    state_t        state_q, state_d;
    logic          owner_q, owner_d;      // 0 = core, 1 = loader
    logic          owner_we_q, owner_we_d;
    logic          last_q, last_d;        // last served, same encoding as owner
    logic [1:0]    cnt_q, cnt_d;
    logic [DW-1:0] c_rdata_q, c_rdata_d;
    logic [DW-1:0] l_rdata_q, l_rdata_d;

    logic elig_core;
    logic elig_ldr;
    logic pick_ldr;

    assign elig_core = c_req & ~l_lock;
    assign elig_ldr  = l_req;
    assign pick_ldr  = elig_ldr & ~(elig_core & last_q);

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        owner_we_d = owner_we_q;
        last_d     = last_q;
        cnt_d      = cnt_q;
        c_rdata_d  = c_rdata_q;
        l_rdata_d  = l_rdata_q;
        m_en       = 1'b0;
        m_we       = 1'b0;
        m_addr     = '0;
        m_wdata    = '0;
        c_ready    = 1'b0;
        l_ready    = 1'b0;
        grant      = 2'b00;

        case (state_q)
            S_IDLE: begin
                if (elig_core || elig_ldr) begin
                    owner_d    = pick_ldr;
                    owner_we_d = pick_ldr ? l_we : c_we;
                    last_d     = pick_ldr;
                    state_d    = S_ACCESS;
                end
            end
            S_ACCESS: begin
                m_en    = 1'b1;
                m_we    = owner_we_q;
                m_addr  = owner_q ? l_addr : c_addr;
                m_wdata = owner_q ? l_wdata : c_wdata;
                grant   = owner_q ? 2'b10 : 2'b01;
                cnt_d   = 2'd0;
                state_d = (owner_we_q || (RD_LAT == 1)) ? S_RESP : S_WAIT;
            end
            S_WAIT: begin
                grant = owner_q ? 2'b10 : 2'b01;
                if (cnt_q == WAIT_LAST) begin
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
            S_RESP: begin
                grant   = owner_q ? 2'b10 : 2'b01;
                c_ready = ~owner_q;
                l_ready = owner_q;
                // Read data passes straight through this cycle and is held afterwards.
                if (!owner_we_q) begin
                    if (owner_q) l_rdata_d = m_rdata;
                    else         c_rdata_d = m_rdata;
                end
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (rst) begin
            m_en    = 1'b0;
            m_we    = 1'b0;
            m_addr  = '0;
            m_wdata = '0;
            c_ready = 1'b0;
            l_ready = 1'b0;
        end
    end

    assign c_rdata = c_rdata_d;
    assign l_rdata = l_rdata_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            owner_q    <= 1'b0;
            owner_we_q <= 1'b0;
            last_q     <= 1'b1;
            cnt_q      <= 2'd0;
            c_rdata_q  <= '0;
            l_rdata_q  <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            owner_we_q <= owner_we_d;
            last_q     <= last_d;
            cnt_q      <= cnt_d;
            c_rdata_q  <= c_rdata_d;
            l_rdata_q  <= l_rdata_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// tb_mem_arbiter : three arbiters (RD_LAT 1, 3, 2) each with a memory model.
// Revision       : 1.0
// ============================================================================
module tb_mem_arbiter;

    logic clk;
    logic rst;
    logic mem_init;

    logic        c_req [3], c_we [3], l_req [3], l_we [3], l_lock [3];
    logic [31:0] c_addr [3], c_wdata [3], l_addr [3], l_wdata [3];
    logic        c_ready [3], l_ready [3], m_en [3], m_we [3];
    logic [31:0] c_rdata [3], l_rdata [3], m_addr [3], m_wdata [3], m_rdata [3];
    logic [1:0]  grant [3];

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        bit          port;     // 0 core, 1 loader
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        int          exp_lat;
    } vec_t;

    vec_t tbl [8];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar gi = 0; gi < 3; gi++) begin : g_dut
        localparam int LAT = (gi == 0) ? 1 : ((gi == 1) ? 3 : 2);
        logic [31:0] mem  [64];
        logic [31:0] pipe [4];

        mem_arbiter #(.AW(32), .DW(32), .RD_LAT(LAT)) u_dut (
            .clk     (clk),
            .rst     (rst),
            .c_req   (c_req[gi]),
            .c_we    (c_we[gi]),
            .c_addr  (c_addr[gi]),
            .c_wdata (c_wdata[gi]),
            .c_ready (c_ready[gi]),
            .c_rdata (c_rdata[gi]),
            .l_req   (l_req[gi]),
            .l_we    (l_we[gi]),
            .l_addr  (l_addr[gi]),
            .l_wdata (l_wdata[gi]),
            .l_lock  (l_lock[gi]),
            .l_ready (l_ready[gi]),
            .l_rdata (l_rdata[gi]),
            .m_en    (m_en[gi]),
            .m_we    (m_we[gi]),
            .m_addr  (m_addr[gi]),
            .m_wdata (m_wdata[gi]),
            .m_rdata (m_rdata[gi]),
            .grant   (grant[gi])
        );

        always @(posedge clk) begin
            if (mem_init) begin
                for (int i = 0; i < 64; i++) mem[i] <= 32'h100 + 32'(i);
                mem[4] <= 32'hDEADBEEF;
            end else if (m_en[gi] && m_we[gi]) begin
                mem[m_addr[gi][7:2]] <= m_wdata[gi];
            end
            pipe[0] <= mem[m_addr[gi][7:2]];
            for (int k = 1; k < 4; k++) pipe[k] <= pipe[k-1];
        end

        assign m_rdata[gi] = pipe[LAT-1];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Starts and ends at posedge+1; returns ready cycle (-1 on timeout).
    task automatic do_access(input int k, input bit port, input bit we,
                             input logic [31:0] addr, input logic [31:0] wdata,
                             output int lat, output logic [31:0] rd,
                             output logic [31:0] maddr, output bit mwe, output int en_cnt);
        lat = -1; rd = '0; maddr = '0; mwe = 1'b0; en_cnt = 0;
        if (port) begin
            l_req[k] = 1'b1; l_we[k] = we; l_addr[k] = addr; l_wdata[k] = wdata;
        end else begin
            c_req[k] = 1'b1; c_we[k] = we; c_addr[k] = addr; c_wdata[k] = wdata;
        end
        for (int n = 0; n < 12; n++) begin
            #3;
            if (m_en[k]) begin
                en_cnt++; maddr = m_addr[k]; mwe = m_we[k];
            end
            if (port ? l_ready[k] : c_ready[k]) begin
                lat = n; rd = port ? l_rdata[k] : c_rdata[k];
            end
            @(posedge clk); #1;
            if (lat >= 0) break;
        end
        c_req[k] = 1'b0; l_req[k] = 1'b0;
    endtask

    task automatic tie(input int k, input bit core_first);
        int tc = -1;
        int tl = -1;
        c_we[k] = 1'b0; c_addr[k] = 32'h10; l_we[k] = 1'b0; l_addr[k] = 32'h14;
        c_req[k] = 1'b1; l_req[k] = 1'b1;
        for (int n = 0; n < 16 && (tc < 0 || tl < 0); n++) begin
            #3;
            if (c_ready[k]) begin tc = n; chk("tie c_rdata", c_rdata[k], 32'hDEADBEEF); end
            if (l_ready[k]) begin tl = n; chk("tie l_rdata", l_rdata[k], 32'h105); end
            @(posedge clk); #1;
            if (tc >= 0) c_req[k] = 1'b0;
            if (tl >= 0) l_req[k] = 1'b0;
        end
        c_req[k] = 1'b0; l_req[k] = 1'b0;
        chk("tie core ready cycle", 32'(tc), core_first ? 32'd2 : 32'd5);
        chk("tie loader ready cycle", 32'(tl), core_first ? 32'd5 : 32'd2);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int lat, en_cnt, rdy, first;
        logic [31:0] rd, maddr;
        logic [31:0] exp_c, exp_l;
        bit mwe;

        tbl[0] = '{0, 0, 32'h10, 32'h0,         32'hDEADBEEF, 2};
        tbl[1] = '{1, 1, 32'h20, 32'hAABBCCDD,  32'h0,        2};
        tbl[2] = '{0, 0, 32'h20, 32'h0,         32'hAABBCCDD, 2};
        tbl[3] = '{1, 0, 32'h10, 32'h0,         32'hDEADBEEF, 2};
        tbl[4] = '{0, 1, 32'h24, 32'h5A5A0000,  32'h0,        2};
        tbl[5] = '{1, 0, 32'h24, 32'h0,         32'h5A5A0000, 2};
        tbl[6] = '{1, 0, 32'hFC, 32'h0,         32'h13F,      2};
        tbl[7] = '{0, 0, 32'h00, 32'h0,         32'h100,      2};

        for (int k = 0; k < 3; k++) begin
            c_req[k] = 0; c_we[k] = 0; c_addr[k] = 0; c_wdata[k] = 0;
            l_req[k] = 0; l_we[k] = 0; l_addr[k] = 0; l_wdata[k] = 0; l_lock[k] = 0;
        end
        rst = 1'b1; mem_init = 1'b1;
        repeat (3) @(posedge clk);
        #1; rst = 1'b0; mem_init = 1'b0;

        #3;
        for (int k = 0; k < 3; k++) begin
            chk("reset grant", 32'(grant[k]), 32'd0);
            chk("reset m_en", 32'(m_en[k]), 32'd0);
            chk("reset c_ready", 32'(c_ready[k] | l_ready[k]), 32'd0);
            chk("reset c_rdata", c_rdata[k], 32'h0);
            chk("reset l_rdata", l_rdata[k], 32'h0);
        end
        @(posedge clk); #1;

        // Ties after reset: core wins first, and again after the loader went last.
        tie(0, 1'b1);
        tie(0, 1'b1);
        exp_c = 32'hDEADBEEF; exp_l = 32'h105;

        for (int i = 0; i < 8; i++) begin
            do_access(0, tbl[i].port, tbl[i].we, tbl[i].addr, tbl[i].wdata, lat, rd, maddr, mwe, en_cnt);
            chk($sformatf("vec%0d latency", i), 32'(lat), 32'(tbl[i].exp_lat));
            chk($sformatf("vec%0d m_en cycles", i), 32'(en_cnt), 32'd1);
            chk($sformatf("vec%0d m_addr", i), maddr, tbl[i].addr);
            chk($sformatf("vec%0d m_we", i), 32'(mwe), 32'(tbl[i].we));
            if (!tbl[i].we) begin
                chk($sformatf("vec%0d rdata", i), rd, tbl[i].exp_rd);
                if (tbl[i].port) exp_l = tbl[i].exp_rd;
                else             exp_c = tbl[i].exp_rd;
            end
            chk($sformatf("vec%0d c_rdata hold", i), c_rdata[0], exp_c);
            chk($sformatf("vec%0d l_rdata hold", i), l_rdata[0], exp_l);
        end

        // Core went last, so the loader wins this tie.
        tie(0, 1'b0);

        // Lock rises during a core access: it completes, then the core is locked out.
        c_req[0] = 1'b1; c_we[0] = 1'b0; c_addr[0] = 32'h10;
        rdy = 0; en_cnt = 0; first = -1;
        for (int n = 0; n < 24; n++) begin
            #3;
            if (m_en[0]) en_cnt++;
            if (c_ready[0]) begin rdy++; first = n; end
            @(posedge clk); #1;
            if (n == 0) l_lock[0] = 1'b1;
        end
        chk("lock c_ready pulses", 32'(rdy), 32'd1);
        chk("lock c_ready cycle", 32'(first), 32'd2);
        chk("lock m_en cycles", 32'(en_cnt), 32'd1);
        #3;
        chk("lock grant", 32'(grant[0]), 32'd0);
        @(posedge clk); #1;
        l_lock[0] = 1'b0;
        first = -1;
        for (int n = 0; n < 6 && first < 0; n++) begin
            #3;
            if (c_ready[0]) first = n;
            @(posedge clk); #1;
            if (first >= 0) c_req[0] = 1'b0;
        end
        c_req[0] = 1'b0;
        chk("lock release ready cycle", 32'(first), 32'd2);
        chk("lock release c_rdata", c_rdata[0], 32'hDEADBEEF);

        // Reset during the ACCESS cycle of a loader write.
        l_req[0] = 1'b1; l_we[0] = 1'b1; l_addr[0] = 32'h44; l_wdata[0] = 32'hCAFEF00D;
        @(posedge clk); #1;
        rst = 1'b1;
        #3;
        chk("rst m_en", 32'(m_en[0]), 32'd0);
        chk("rst m_we", 32'(m_we[0]), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0; l_req[0] = 1'b0; l_we[0] = 1'b0;
        #3;
        chk("post-rst grant", 32'(grant[0]), 32'd0);
        chk("post-rst l_ready", 32'(l_ready[0]), 32'd0);
        chk("post-rst c_rdata", c_rdata[0], 32'h0);
        chk("post-rst mem", g_dut[0].mem[17], 32'h111);
        @(posedge clk); #1;

        // RD_LAT=3: loader write then core read of the same word.
        do_access(1, 1'b1, 1'b1, 32'h40, 32'h12345678, lat, rd, maddr, mwe, en_cnt);
        chk("lat3 write latency", 32'(lat), 32'd2);
        do_access(1, 1'b0, 1'b0, 32'h40, 32'h0, lat, rd, maddr, mwe, en_cnt);
        chk("lat3 read latency", 32'(lat), 32'd4);
        chk("lat3 read data", rd, 32'h12345678);
        chk("lat3 m_en cycles", 32'(en_cnt), 32'd1);

        // RD_LAT=2: core drops req during WAIT.
        c_req[2] = 1'b1; c_we[2] = 1'b0; c_addr[2] = 32'h10;
        rdy = 0; en_cnt = 0; first = -1; rd = '0;
        for (int n = 0; n < 10; n++) begin
            #3;
            if (m_en[2]) en_cnt++;
            if (c_ready[2]) begin rdy++; first = n; rd = c_rdata[2]; end
            @(posedge clk); #1;
            if (n == 1) c_req[2] = 1'b0;
        end
        chk("drop c_ready pulses", 32'(rdy), 32'd1);
        chk("drop c_ready cycle", 32'(first), 32'd3);
        chk("drop m_en cycles", 32'(en_cnt), 32'd1);
        chk("drop rdata", rd, 32'hDEADBEEF);
        #3;
        chk("drop grant idle", 32'(grant[2]), 32'd0);
        chk("drop rdata held", c_rdata[2], 32'hDEADBEEF);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
